// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage core. It turns hazard, EX redirect
// and memory-stall requests into per-stage write enables, IF/ID flushes and
// ID/EX bubbles. It also keeps saturating statistics and a sticky watchdog
// for stalls that never clear.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_i,
    input  logic             redirect_i,
    input  logic             ext_stall_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             wdog_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // The consecutive-stall counter must be able to hold WDOG_LIMIT itself.
    localparam int         SC_W    = $clog2(WDOG_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(WDOG_LIMIT);
    localparam logic [SC_W-1:0] SC_TRIP = SC_W'(WDOG_LIMIT - 1);
    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [SC_W-1:0]  consec_q, consec_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             wdog_q, wdog_d;
    logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze;

    // Priority decode: memory stall freezes everything, then redirect, then
    // the remaining flush cycles, then hazard stall, else run.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        consec_d     = consec_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        wdog_d       = wdog_q;
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (ext_stall_i) begin
            // Everything holds; a pending redirect stays asserted by EX.
            pipe_freeze = 1'b1;
        end else if (redirect_i) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            consec_d     = '0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            if (FLUSH_CYCLES == 1) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                state_d = ST_FLUSH;
                fcnt_d  = FL_INIT;
            end
        end else if (state_q == ST_FLUSH) begin
            // Hazard is irrelevant here: the ID instruction is being discarded.
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            consec_d     = '0;
            if (fcnt_q <= 4'd1) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - 4'd1;
            end
        end else if (hazard_i) begin
            id_ex_bubble = 1'b1;
            state_d      = ST_STALL;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (consec_q >= SC_TRIP) wdog_d = 1'b1;
            if (consec_q != SC_MAX) consec_d = consec_q + 1'b1;
        end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            state_d  = ST_RUN;
            consec_d = '0;
        end
    end

    // State and statistics registers; reset aborts any stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            consec_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            consec_q    <= consec_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    // Control outputs are forced low while reset is held.
    assign pc_we_o        = rst_n & pc_we;
    assign if_id_we_o     = rst_n & if_id_we;
    assign if_id_flush_o  = rst_n & if_id_flush;
    assign id_ex_bubble_o = rst_n & id_ex_bubble;
    assign pipe_freeze_o  = rst_n & pipe_freeze;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign wdog_o         = wdog_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench: DUT a (FLUSH_CYCLES=2, WDOG_LIMIT=4, CNT_W=8) runs the
// vector table; DUT b (FLUSH_CYCLES=3, CNT_W=4) shares inputs and covers
// counter saturation, reset mid-flush and redirect restart.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n, hz, rd, ex;
    logic a_pc, a_we, a_fl, a_bb, a_fz, a_wd;
    logic b_pc, b_we, b_fl, b_bb, b_fz, b_wd;
    logic [7:0] a_sc, a_fc;
    logic [3:0] b_sc, b_fc;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .WDOG_LIMIT(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .hazard_i(hz), .redirect_i(rd), .ext_stall_i(ex),
        .pc_we_o(a_pc), .if_id_we_o(a_we), .if_id_flush_o(a_fl),
        .id_ex_bubble_o(a_bb), .pipe_freeze_o(a_fz),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc), .wdog_o(a_wd));

    pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .hazard_i(hz), .redirect_i(rd), .ext_stall_i(ex),
        .pc_we_o(b_pc), .if_id_we_o(b_we), .if_id_flush_o(b_fl),
        .id_ex_bubble_o(b_bb), .pipe_freeze_o(b_fz),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc), .wdog_o(b_wd));

    // out = {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}
    typedef struct {
        logic       hz, rd, ex;
        logic [4:0] out;
        logic [7:0] sc, fc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic h, logic r, logic e, logic [4:0] o, int s, int f);
        vec_t v;
        v.hz = h; v.rd = r; v.ex = e; v.out = o; v.sc = 8'(s); v.fc = 8'(f);
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(0, 0, 0, 5'b11000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 5'b00010, 0, 0);
        tbl[2]  = mk(1, 0, 0, 5'b00010, 1, 0);
        tbl[3]  = mk(0, 0, 0, 5'b11000, 2, 0);
        tbl[4]  = mk(1, 1, 0, 5'b11110, 2, 0);  // redirect beats hazard
        tbl[5]  = mk(1, 0, 0, 5'b11110, 2, 1);  // FLUSH ignores hazard
        tbl[6]  = mk(0, 0, 0, 5'b11000, 2, 1);
        tbl[7]  = mk(1, 1, 1, 5'b00001, 2, 1);  // ext stall beats all
        tbl[8]  = mk(1, 1, 1, 5'b00001, 2, 1);
        tbl[9]  = mk(1, 1, 1, 5'b00001, 2, 1);
        tbl[10] = mk(1, 1, 0, 5'b11110, 2, 1);  // held redirect taken
        tbl[11] = mk(0, 0, 0, 5'b11110, 2, 2);
        tbl[12] = mk(0, 0, 0, 5'b11000, 2, 2);
        tbl[13] = mk(0, 0, 1, 5'b00001, 2, 2);
        tbl[14] = mk(1, 0, 0, 5'b00010, 2, 2);
        tbl[15] = mk(1, 0, 1, 5'b00001, 3, 2);  // freeze inside STALL
        tbl[16] = mk(1, 0, 0, 5'b00010, 3, 2);
        tbl[17] = mk(0, 0, 0, 5'b11000, 4, 2);

        // Reset state
        rst_n = 1'b0; hz = 0; rd = 0; ex = 0;
        #12;
        chk("rst_out_a", {a_pc, a_we, a_fl, a_bb, a_fz}, 5'b0);
        chk("rst_out_b", {b_pc, b_we, b_fl, b_bb, b_fz}, 5'b0);
        chk("rst_cnt_a", {a_sc, a_fc, 7'b0, a_wd}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors on DUT a
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            hz = tbl[i].hz; rd = tbl[i].rd; ex = tbl[i].ex;
            #2;
            chk($sformatf("vec%0d_out", i), {a_pc, a_we, a_fl, a_bb, a_fz}, tbl[i].out);
            chk($sformatf("vec%0d_cnt", i), {a_sc, a_fc}, {tbl[i].sc, tbl[i].fc});
            chk($sformatf("vec%0d_wd", i), a_wd, 0);
        end
        chk("b_sc_after_tbl", b_sc, 4);
        chk("b_fc_after_tbl", b_fc, 2);

        // Watchdog: hazard held 5 cycles, trips after the 4th stall cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hz = 1; rd = 0; ex = 0;
            #2;
            chk($sformatf("wd_cyc%0d", i), a_wd, (i >= 4) ? 1 : 0);
            chk($sformatf("wd_bub%0d", i), {a_pc, a_bb}, 2'b01);
        end
        @(negedge clk) hz = 0;
        #2;
        chk("wd_sticky", a_wd, 1);
        chk("wd_sc_a", a_sc, 9);
        chk("wd_b_clear", b_wd, 0);
        chk("wd_run_out", {a_pc, a_we, a_fl, a_bb, a_fz}, 5'b11000);

        // Saturation: 10 more stall cycles, b's 4-bit counter pins at 15
        hz = 1;
        repeat (10) @(negedge clk);
        hz = 0;
        #2;
        chk("sat_sc_a", a_sc, 19);
        chk("sat_sc_b", b_sc, 15);

        // Reset in the middle of a 3-cycle flush on DUT b
        @(negedge clk) rd = 1;
        @(negedge clk) rd = 0;
        #2;
        chk("mid_flush_b", {b_fl, b_bb, b_pc}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("async_out_a", {a_pc, a_we, a_fl, a_bb, a_fz}, 5'b0);
        chk("async_out_b", {b_pc, b_we, b_fl, b_bb, b_fz}, 5'b0);
        chk("async_cnt_b", {b_sc, b_fc, 3'b0, b_wd}, 0);
        chk("async_wd_a", a_wd, 0);
        @(negedge clk) rst_n = 1'b1;
        #2;
        chk("post_rst_b", {b_pc, b_we, b_fl, b_bb, b_fz}, 5'b11000);
        @(negedge clk);
        #2;
        chk("post_rst_b2", {b_pc, b_we, b_fl, b_bb, b_fz}, 5'b11000);

        // Redirect during FLUSH restarts the count on DUT b
        begin
            logic [5:0] rseq;
            logic [5:0] fexp;
            rseq = 6'b000101;  // bit i = redirect in cycle i
            fexp = 6'b011111;  // bit i = expected flush in cycle i
            for (int i = 0; i < 6; i++) begin
                @(negedge clk) rd = rseq[i];
                #2;
                chk($sformatf("restart%0d", i), b_fl, fexp[i]);
            end
        end
        chk("restart_fc_b", b_fc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
